// File: rtl/mosfet_pkg.sv
// Shared types and constants for the MOSFET scheduling controller.
package mosfet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam int N_MOS = 6;
  localparam int ID_W  = 10;
  localparam int GM_W  = 6;

  // A metric slot must hold either quantity; ID is the wider one.
  localparam int MET_W = ID_W;
  localparam int SUM_W = 14;

  typedef logic [MET_W-1:0] metric_t;
  typedef logic [SUM_W-1:0] sum_t;

  function automatic metric_t select_metric(input logic use_id,
                                            input logic [ID_W-1:0] id,
                                            input logic [GM_W-1:0] gm);
    return use_id ? metric_t'(id) : metric_t'(gm);
  endfunction

endpackage

// File: rtl/mosfet_eval.sv
// Combinational per-transistor evaluation: region, drain current and
// transconductance from W, V_GS and V_DS.
module mosfet_eval
  import mosfet_pkg::*;
(
  input  logic [2:0]      W,
  input  logic [2:0]      V_GS,
  input  logic [2:0]      V_DS,
  output logic [ID_W-1:0] id,
  output logic [GM_W-1:0] gm,
  output logic            triode
);

  logic [3:0]  vov;
  logic [4:0]  tri_fac;
  logic [15:0] id_tri, id_sat, gm_tri, gm_sat;

  // Overdrive wraps for V_GS=0; such inputs are out of range anyway.
  assign vov     = {1'b0, V_GS} - 4'd1;
  assign tri_fac = {1'b0, V_GS, 1'b0} - 5'd2 - {2'b00, V_DS};

  always_comb begin
    triode = (vov > {1'b0, V_DS});
    id_tri = 16'(W) * 16'(V_DS) * 16'(tri_fac);
    id_sat = 16'(W) * 16'(vov) * 16'(vov);
    gm_tri = 16'd2 * 16'(W) * 16'(V_DS);
    gm_sat = 16'd2 * 16'(W) * 16'(vov);
    if (triode) begin
      id = ID_W'(id_tri / 16'd3);
      gm = GM_W'(gm_tri / 16'd3);
    end else begin
      id = ID_W'(id_sat / 16'd3);
      gm = GM_W'(gm_sat / 16'd3);
    end
  end

endmodule

// File: rtl/mosfet_sched_ctrl.sv
// Frame controller: collects six transistor beats into a descending sorted
// array, then averages the top or bottom three. Build option
// MOSFET_SCHED_RESULT_HOLD_EN keeps out_n at the last result outside OUT.
module mosfet_sched_ctrl
  import mosfet_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [1:0]      mode,
  input  logic [2:0]      W,
  input  logic [2:0]      V_GS,
  input  logic [2:0]      V_DS,
  output logic            in_ready,
  output logic            out_valid,
  output logic [ID_W-1:0] out_n
);

`ifdef MOSFET_SCHED_RESULT_HOLD_EN
  localparam bit HOLD_RESULT = 1'b1;
`else
  localparam bit HOLD_RESULT = 1'b0;
`endif

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [1:0]      mode_q;
  metric_t         s_q [N_MOS];
  metric_t         s_d [N_MOS];
  logic            out_valid_q;
  logic [ID_W-1:0] out_n_q;

  logic            accept;
  logic            use_id;
  logic [ID_W-1:0] beat_id;
  logic [GM_W-1:0] beat_gm;
  logic            beat_triode;
  metric_t         beat_met;
  logic [N_MOS-1:0] ge;
  logic [ID_W-1:0] result;

  mosfet_eval u_eval (
    .W      (W),
    .V_GS   (V_GS),
    .V_DS   (V_DS),
    .id     (beat_id),
    .gm     (beat_gm),
    .triode (beat_triode)
  );

  function automatic logic [ID_W-1:0] calc_result(input logic id_sel,
                                                  input metric_t a,
                                                  input metric_t b,
                                                  input metric_t c);
    sum_t sum;
    sum_t quo;
    if (id_sel) begin
      sum = sum_t'(a) * sum_t'(3) + sum_t'(b) * sum_t'(4) + sum_t'(c) * sum_t'(5);
      quo = sum / sum_t'(12);
    end else begin
      sum = sum_t'(a) + sum_t'(b) + sum_t'(c);
      quo = sum / sum_t'(3);
    end
    return ID_W'(quo);
  endfunction

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

  // The first beat of a frame uses the live mode; later beats the latched one.
  assign use_id   = (state_q == ST_IDLE) ? mode[0] : mode_q[0];
  assign beat_met = select_metric(use_id, beat_id, beat_gm);

  // Insertion: ge marks the valid prefix that stays put (>= keeps ties ahead).
  always_comb begin
    for (int i = 0; i < N_MOS; i++) begin
      ge[i] = (3'(i) < cnt_q) && (s_q[i] >= beat_met);
    end
    s_d[0] = ge[0] ? s_q[0] : beat_met;
    for (int i = 1; i < N_MOS; i++) begin
      if (ge[i])        s_d[i] = s_q[i];
      else if (ge[i-1]) s_d[i] = beat_met;
      else              s_d[i] = s_q[i-1];
    end
  end

  always_comb begin
    if (mode_q[1]) result = calc_result(mode_q[0], s_q[0], s_q[1], s_q[2]);
    else           result = calc_result(mode_q[0], s_q[3], s_q[4], s_q[5]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
      for (int i = 0; i < N_MOS; i++) s_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (!HOLD_RESULT) out_n_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mode_q  <= mode;
            s_q     <= s_d;
            cnt_q   <= 3'd1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            s_q <= s_d;
            if (cnt_q == 3'(N_MOS - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_CALC;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        ST_CALC: begin
          out_valid_q <= 1'b1;
          out_n_q     <= result;
          state_q     <= ST_OUT;
        end
        ST_OUT:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mosfet_sched_ctrl.md
MOSFET_SCHED_CTRL -- requirements
Module: mosfet_sched_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  transistor beat present
- mode  in  2  frame mode; sampled on the first accepted beat of a frame only
- W  in  3  channel width, legal range 1..7
- V_GS  in  3  gate-source voltage, legal range 1..7
- V_DS  in  3  drain-source voltage, legal range 1..7
- in_ready  out  1  beat accepted when in_valid & in_ready at a rising edge
- out_valid  out  1  result strobe
- out_n  out  10  frame result

Function
REQ-003 A frame SHALL consist of exactly six accepted beats; beat k SHALL be transistor k (0..5).
REQ-004 The FSM SHALL have the states IDLE, LOAD, CALC and OUT. Transitions:
- IDLE->LOAD on the first accept.
- LOAD->CALC on the sixth accept.
- CALC->OUT unconditionally.
- OUT->IDLE unconditionally.
REQ-005 in_ready SHALL be 1 in IDLE and LOAD, and 0 in CALC and OUT; in_valid SHALL be ignored while in_ready=0.
REQ-006 In LOAD, cycles with in_valid=0 SHALL hold state, beat count and sorted array unchanged (gaps allowed).
REQ-007 Per beat, a transistor is triode iff (V_GS-1) > V_DS (compared unsigned, 4-bit); otherwise it is saturation.
REQ-008 Drain current ID (10b) and transconductance gm (6b) SHALL be computed as follows, with truncating integer division:
- Triode: ID = W*V_DS*(2*V_GS-2-V_DS)/3 and gm = 2*W*V_DS/3.
- Saturation: ID = W*(V_GS-1)^2/3 and gm = 2*W*(V_GS-1)/3.
REQ-009 The metric SHALL be ID when the latched mode[0]=1, and gm when mode[0]=0.
REQ-010 The metric SHALL be inserted into a six-entry array kept sorted descending (s0 largest) on the same edge that accepts the beat. Equal values SHALL be inserted after existing equal entries.
REQ-011 In CALC the result SHALL be computed and registered as follows:
- ID metric, mode[1]=1: (3*s0+4*s1+5*s2)/12.
- ID metric, mode[1]=0: (3*s3+4*s4+5*s5)/12.
- gm metric, mode[1]=1: (s0+s1+s2)/3.
- gm metric, mode[1]=0: (s3+s4+s5)/3.
- Intermediate sums SHALL be at least 12 bits; division SHALL truncate.
REQ-012 out_valid SHALL be 1 for exactly the one cycle in OUT, which is the second cycle after the sixth-accept edge.
REQ-013 The next frame's first beat SHALL be accepted no earlier than the cycle after OUT.
REQ-014 Inputs outside 1..7 SHALL produce an unspecified out_n but SHALL NOT corrupt FSM sequencing.

Reset
REQ-015 While rst_n=0 at a rising edge, the block SHALL:
- set the state to IDLE;
- clear the beat count, latched mode and sorted array to 0;
- drive out_valid=0 and out_n=0.
REQ-016 A reset during LOAD, CALC or OUT SHALL discard the partial frame; no out_valid SHALL follow for that frame.

Configuration
REQ-017 The macro MOSFET_SCHED_RESULT_HOLD_EN SHALL select how out_n behaves outside OUT:
- Defined: out_n SHALL hold the last result until the next OUT or reset.
- Undefined: out_n SHALL be 0 whenever out_valid=0.

Structure
REQ-018 A shared package mosfet_pkg SHALL hold:
- the FSM state enum;
- the constants N_MOS=6, ID_W=10 and GM_W=6;
- the metric width definitions.
REQ-019 The per-transistor ID/gm computation SHALL be a combinational sub-module mosfet_eval (inputs W, V_GS, V_DS; outputs id, gm, triode); the sort, FSM and averaging logic SHALL stay in mosfet_sched_ctrl.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- mode=11, six beats W=7,V_GS=7,V_DS=7 (saturation, ID=84) -> out_n=84, out_valid two cycles after beat 6.
- mode=01, six beats W=3,V_GS=5,V_DS=2 (triode, ID=12) -> out_n=12.
- mode=10, three beats W=7,V_GS=7,V_DS=7 (gm=28) interleaved with three beats W=1,V_GS=1,V_DS=1 (gm=0), with 2-cycle in_valid gaps -> out_n=28; mode=00 with the same beats -> out_n=0.
- Three beats of a mode=11 frame, rst_n low for one cycle, then a full mode=01 frame of W=3,V_GS=5,V_DS=2 -> exactly one out_valid, with out_n=12.
- in_valid held high through CALC/OUT -> in_ready=0 there; those beats are not counted; out_n outside OUT is checked against both settings of MOSFET_SCHED_RESULT_HOLD_EN.
- Random legal frames (10k) compared against a reference model using REQ-007..REQ-011.
